instruction_fetch_unit: RTL

- Drives the program-ROM address bus and captures the combinational instruction word the ROM returns.
- Folds unconditional JMP locally: the PC is redirected in fetch and the JMP is not forwarded.
- Buffers fetched words in a 2-entry queue and presents them, tagged with their PC, to the decode stage over a valid/ready handshake.
- Accepts a flush/redirect from execute for taken BLE branches.

---
 rtl/instruction_fetch_unit_pkg.sv | 45 ++++
 rtl/instruction_fetch_unit_fetch_queue.sv | 81 ++++++++
 rtl/instruction_fetch_unit.sv | 77 +++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, opcodes, field ranges,
// queue entry payload and queue occupancy states.
package instruction_fetch_unit_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 28;
  localparam int unsigned QDEPTH  = 2;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FIELD_W = 8;

  localparam int unsigned OPC_HI = 27;
  localparam int unsigned OPC_LO = 24;
  localparam int unsigned FA_HI  = 23;
  localparam int unsigned FA_LO  = 16;
  localparam int unsigned FB_HI  = 15;
  localparam int unsigned FB_LO  = 8;
  localparam int unsigned FC_HI  = 7;
  localparam int unsigned FC_LO  = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'd0,
    OP_STO = 4'd1,
    OP_ADD = 4'd2,
    OP_MUL = 4'd3,
    OP_LED = 4'd4,
    OP_BLE = 4'd5,
    OP_JMP = 4'd6
  } opcode_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  function automatic logic is_jmp(input logic [INSTR_W-1:0] word);
    return word[OPC_HI:OPC_LO] == OPC_W'(OP_JMP);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Two-entry in-order fetch queue; entry 0 is the head. Flush empties the queue
// but leaves the head register untouched so the outputs hold their last value.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic         full_o
);

  q_state_e     state_q, state_d;
  fetch_entry_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic         valid_q, valid_d, full_q, full_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Q_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  // Occupancy transitions; simultaneous push and pop keep the state.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = Q_EMPTY;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (state_q == Q_EMPTY)    state_d = Q_ONE;
          else if (state_q == Q_ONE) state_d = Q_FULL;
        end
        2'b01: begin
          if (state_q == Q_FULL)     state_d = Q_ONE;
          else if (state_q == Q_ONE) state_d = Q_EMPTY;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (!flush_i) begin
      if (pop_i && state_q == Q_FULL) ent0_d = ent1_q;
      if (push_i) begin
        unique case (state_q)
          Q_EMPTY: ent0_d = data_i;
          Q_ONE: begin
            if (pop_i) ent0_d = data_i;
            else       ent1_d = data_i;
          end
          default: ent1_d = data_i;
        endcase
      end
    end
    valid_d = (state_d != Q_EMPTY);
    full_d  = (state_d == Q_FULL);
  end

  assign head_o  = ent0_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the ROM address from the PC, folds JMP locally, queues
// fetched words for decode and takes branch redirects from execute.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic               oInstrValid,
  input  logic               iDecodeReady,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oInstrPC,
  input  logic               iRedirect,
  input  logic [ADDR_W-1:0]  iRedirectTarget,
  output logic               oJmpFolded
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fold_q, fold_d;
  logic              push_c, flush_c, pop_c, space_c, jmp_c;
  logic              q_valid, q_full;
  fetch_entry_t      push_entry, head;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q   <= '0;
      fold_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      fold_q <= fold_d;
    end
  end

  assign pop_c   = q_valid && iDecodeReady;
  assign space_c = !q_full || pop_c;
  assign jmp_c   = is_jmp(iInstruction);

  // Redirect beats JMP folding, which beats a normal capture; no space means stall.
  always_comb begin
    pc_d    = pc_q;
    fold_d  = 1'b0;
    push_c  = 1'b0;
    flush_c = 1'b0;
    if (iRedirect) begin
      flush_c = 1'b1;
      pc_d    = iRedirectTarget;
    end else if (space_c && jmp_c) begin
      pc_d   = ADDR_W'(iInstruction[FA_HI:FA_LO]);
      fold_d = 1'b1;
    end else if (space_c) begin
      push_c = 1'b1;
      pc_d   = pc_q + ADDR_W'(1);
    end
  end

  assign push_entry = '{instr: iInstruction, pc: pc_q};

  fetch_queue u_fetch_queue (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (flush_c),
    .data_i  (push_entry),
    .head_o  (head),
    .valid_o (q_valid),
    .full_o  (q_full)
  );

  assign oAddress     = pc_q;
  assign oInstrValid  = q_valid;
  assign oInstruction = head.instr;
  assign oInstrPC     = head.pc;
  assign oJmpFolded   = fold_q;

endmodule
